// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int DEPTH_DEF = 2;
    localparam int PC_INC    = 4;

    // ISSUE: nothing outstanding; WAIT: request accepted, response wanted;
    // DRAIN: request outstanding but its response will be thrown away.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory and the core.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;

    // Fetch unit side.
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    // Memory and core side.
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs with a combinational head read.
module fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [2*XLEN-1:0]      push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [2*XLEN-1:0]      head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [2*XLEN-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    // Storage, pointers and occupancy; flush empties the queue but keeps the
    // read pointer so the head output simply goes stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= rd_ptr_r;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps one memory request in
// flight at most, queues returned words with their PC and handles redirects.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_state_t      state_r;
    logic [XLEN-1:0]   fetch_pc_r;
    logic [XLEN-1:0]   inflight_pc_r;

    logic [CW-1:0]     count_s;
    logic [2*XLEN-1:0] head_s;
    logic [XLEN-1:0]   redirect_tgt_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              push_s;
    logic              pop_s;
    logic              instr_valid_s;

    // Request, push and pop qualifiers; a redirect masks both the request and
    // the head so nothing from the wrong path leaves in the redirect cycle.
    always_comb begin
        redirect_tgt_s = {bus.redirect_pc[XLEN-1:2], 2'b00};
        req_valid_s    = reset && (state_r == ISSUE) && (count_s < FULL_COUNT)
                         && !bus.redirect_valid;
        req_fire_s     = req_valid_s && bus.imem_req_ready;
        push_s         = (state_r == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
        instr_valid_s  = (count_s != '0) && !bus.redirect_valid;
        pop_s          = instr_valid_s && bus.instr_ready;
    end

    // Fetch FSM with the fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ISSUE;
            fetch_pc_r    <= RESET_PC;
            inflight_pc_r <= '0;
        end else begin
            case (state_r)
                ISSUE: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_r <= redirect_tgt_s;
                        state_r    <= ISSUE;
                    end else if (req_fire_s) begin
                        inflight_pc_r <= fetch_pc_r;
                        fetch_pc_r    <= fetch_pc_r + XLEN'(PC_INC);
                        state_r       <= WAIT;
                    end else begin
                        state_r <= ISSUE;
                    end
                end
                WAIT: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_r <= redirect_tgt_s;
                        // A response landing with the redirect is simply dropped.
                        state_r    <= bus.imem_rsp_valid ? ISSUE : DRAIN;
                    end else if (bus.imem_rsp_valid) begin
                        state_r <= ISSUE;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                DRAIN: begin
                    if (bus.redirect_valid) begin
                        fetch_pc_r <= redirect_tgt_s;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                    if (bus.imem_rsp_valid) begin
                        state_r <= ISSUE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= ISSUE;
                end
            endcase
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .push_data ({inflight_pc_r, bus.imem_rsp_data}),
        .pop       (pop_s),
        .flush     (bus.redirect_valid),
        .count     (count_s),
        .head      (head_s)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.instr_valid    = instr_valid_s;
    assign bus.instr          = head_s[XLEN-1:0];
    assign bus.instr_pc       = head_s[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit plus hand-written reset and
// address-wrap sequences.
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rr;
        logic        rv;
        logic [31:0] rd;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_i;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_miss;

    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D1 = 32'h0010_0093;
    localparam logic [31:0] D2 = 32'h0020_0113;
    localparam logic [31:0] D3 = 32'h0030_0193;
    localparam logic [31:0] DS = 32'hDEAD_BEEF;
    localparam logic [31:0] DX = 32'h0400_2013;
    localparam logic [31:0] DY = 32'h0800_4013;

    task automatic add(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic redir, input logic [31:0] rpc, input logic ir,
                       input logic e_rv, input logic [31:0] e_ra, input logic e_iv,
                       input logic [31:0] e_i, input logic [31:0] e_ipc);
        vec_t v;
        v.rr = rr; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.ir = ir;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_i = e_i; v.e_ipc = e_ipc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                         input logic redir, input logic [31:0] rpc, input logic ir);
        bus.imem_req_ready = rr;
        bus.imem_rsp_valid = rv;
        bus.imem_rsp_data  = rd;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.instr_ready    = ir;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // rr rv rd  redir rpc  ir | req_valid addr  instr_valid instr pc
        // Straight-line fetch, 1-cycle latency; ready held low 3 cycles at 0x4.
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b1, 32'h000, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b1, D0,    1'b0, 32'h0, 1'b1,  1'b0, 32'h004, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b1, 32'h004, 1'b1, D0,    32'h000);
        add(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b1, 32'h004, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b1, 32'h004, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b1, 32'h004, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b1, D1,    1'b0, 32'h0, 1'b1,  1'b0, 32'h008, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b1, 32'h008, 1'b1, D1,    32'h004);
        add(1'b1, 1'b1, D2,    1'b0, 32'h0, 1'b1,  1'b0, 32'h00C, 1'b0, 32'h0, 32'h0);
        // Core stalls: queue fills to two entries, requests stop.
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,  1'b1, 32'h00C, 1'b1, D2,    32'h008);
        add(1'b1, 1'b1, D3,    1'b0, 32'h0, 1'b0,  1'b0, 32'h010, 1'b1, D2,    32'h008);
        for (int i = 0; i < 8; i++) begin
            add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,  1'b0, 32'h010, 1'b1, D2, 32'h008);
        end
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1,  1'b0, 32'h010, 1'b1, D2,    32'h008);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0,  1'b1, 32'h010, 1'b1, D3,    32'h00C);
        // Redirect to 0x100 while waiting: queue flushed, stale response dropped.
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0,  1'b0, 32'h014, 1'b1, D3,  32'h00C);
        add(1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0,  1'b0, 32'h014, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0,  1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b1, DS,    1'b0, 32'h0,   1'b0,  1'b0, 32'h100, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1,  1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
        // Redirect to 0x203 together with the response: no DRAIN, target 0x200.
        add(1'b1, 1'b1, DX,    1'b1, 32'h203, 1'b1,  1'b0, 32'h104, 1'b0, 32'h0, 32'h0);
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1,  1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b1, DY,    1'b0, 32'h0,   1'b1,  1'b0, 32'h204, 1'b0, 32'h0, 32'h0);
        add(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b1,  1'b1, 32'h204, 1'b1, DY,  32'h200);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid",   {31'd0, bus.imem_req_valid}, 32'd0);
        chk("rst_req_addr",    bus.imem_req_addr, 32'h0);
        chk("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr",       bus.instr, 32'h0);
        chk("rst_instr_pc",    bus.instr_pc, 32'h0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].redir, vecs[i].rpc, vecs[i].ir);
            #2;
            n_vec++;
            if (bus.imem_req_valid !== vecs[i].e_rv || bus.imem_req_addr !== vecs[i].e_ra ||
                bus.instr_valid !== vecs[i].e_iv ||
                (vecs[i].e_iv && (bus.instr !== vecs[i].e_i || bus.instr_pc !== vecs[i].e_ipc))) begin
                n_miss++;
                $display("FAIL vec%0d: got rv=%b addr=%h iv=%b instr=%h pc=%h, want rv=%b addr=%h iv=%b instr=%h pc=%h",
                         i, bus.imem_req_valid, bus.imem_req_addr, bus.instr_valid, bus.instr,
                         bus.instr_pc, vecs[i].e_rv, vecs[i].e_ra, vecs[i].e_iv, vecs[i].e_i,
                         vecs[i].e_ipc);
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-WAIT, then a late response after release.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("pre_rst_addr", bus.imem_req_addr, 32'h204);
        @(posedge clk);
        #1;
        chk("wait_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("wait_addr", bus.imem_req_addr, 32'h208);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("midrst_addr", bus.imem_req_addr, 32'h0);
        chk("midrst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 1'b1, 32'hBADB_AD00, 1'b0, 32'h0, 1'b1);
        #1;
        chk("late_rsp_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("late_rsp_addr", bus.imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("late_rsp_no_push", {31'd0, bus.instr_valid}, 32'd0);
        chk("first_req_addr", bus.imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, D0, 1'b0, 32'h0, 1'b1);
        chk("after_first_addr", bus.imem_req_addr, 32'h4);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("post_rst_iv", {31'd0, bus.instr_valid}, 32'd1);
        chk("post_rst_instr", bus.instr, D0);
        chk("post_rst_pc", bus.instr_pc, 32'h0);

        // Redirect with low bits set to the top word, then wrap on increment.
        drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        #1;
        chk("redir_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
        chk("redir_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("top_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        chk("top_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr", bus.imem_req_addr, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("wrap_instr", bus.instr, 32'hCAFE_F00D);
        chk("wrap_instr_pc", bus.instr_pc, 32'hFFFF_FFFC);
        chk("wrap_next_req", {31'd0, bus.imem_req_valid}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
